// File: rtl/exp5_fluxo_dados_pkg.sv
// Shared defaults and fixed pattern ROM contents for the exp5 datapath.
package exp5_fluxo_dados_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;

  typedef logic [3:0] rom_word_t;

  // Pattern sequence the player must reproduce, one-hot per button.
  localparam rom_word_t ROM_INIT [16] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
  };

  function automatic rom_word_t rom_read(input logic [3:0] addr);
    return ROM_INIT[addr];
  endfunction

endpackage

// File: rtl/exp5_fluxo_dados_edge_detector.sv
// One-cycle pulse on the rising edge of a single-bit level.
module exp5_edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  // Remember last cycle's level so a held input pulses only once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/exp5_fluxo_dados.sv
// Datapath for the exp5 memory game: address counter, pattern ROM,
// play register, comparator and button edge detection.
module exp5_fluxo_dados
  import exp5_fluxo_dados_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              zeraC,
  input  logic              contaC,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic [DATA_W-1:0] botoes,
  output logic              fim,
  output logic              jogada,
  output logic              igual,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_memoria,
  output logic [DATA_W-1:0] db_jogada,
  output logic              db_tem_jogada
);

  logic [ADDR_W-1:0] contagem;
  logic [DATA_W-1:0] registro;
  logic [DATA_W-1:0] memoria;
  logic              tem_jogada;

  // Address counter: clear has priority over count; natural wrap at the top.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    contagem <= '0;
    else if (zeraC)  contagem <= '0;
    else if (contaC) contagem <= contagem + ADDR_W'(1);
  end

  // Play register: captures the raw button vector, multi-hot included.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       registro <= '0;
    else if (zeraR)     registro <= '0;
    else if (registraR) registro <= botoes;
  end

  // Asynchronous-read pattern ROM.
  always_comb begin
    memoria = DATA_W'(rom_read(4'(contagem)));
  end

  assign tem_jogada = |botoes;

  exp5_edge_detector u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (tem_jogada),
    .pulse   (jogada)
  );

  assign fim           = (contagem == '1);
  assign igual         = (registro == memoria);
  assign db_contagem   = contagem;
  assign db_memoria    = memoria;
  assign db_jogada     = registro;
  assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_exp5_fluxo_dados.sv
// Scoreboard bench for exp5_fluxo_dados: stimulus pushes expected outputs,
// a monitor on the falling edge pops and compares.
module tb_exp5_fluxo_dados;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       zeraC = 1'b0, contaC = 1'b0, zeraR = 1'b0, registraR = 1'b0;
  logic [3:0] botoes = 4'h0;
  logic       fim, jogada, igual, db_tem_jogada;
  logic [3:0] db_contagem, db_memoria, db_jogada;

  exp5_fluxo_dados #(.ADDR_W(4), .DATA_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR), .botoes(botoes),
    .fim(fim), .jogada(jogada), .igual(igual), .db_contagem(db_contagem),
    .db_memoria(db_memoria), .db_jogada(db_jogada), .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       fim, jogada, igual, tem;
    logic [3:0] cont, mem, jog;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int   m_cnt = 0;
  int   m_reg = 0;
  bit   m_prev = 0;
  int   rom [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: combinational outputs are stable mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fim",         int'(fim),           int'(e.fim));
        chk("jogada",      int'(jogada),        int'(e.jogada));
        chk("igual",       int'(igual),         int'(e.igual));
        chk("db_contagem", int'(db_contagem),   int'(e.cont));
        chk("db_memoria",  int'(db_memoria),    int'(e.mem));
        chk("db_jogada",   int'(db_jogada),     int'(e.jog));
        chk("db_tem",      int'(db_tem_jogada), int'(e.tem));
      end
    end
  end

  // Apply one cycle of inputs just after a rising edge, predict, then advance.
  task automatic step(input bit rst, input bit zc, input bit cc,
                      input bit zr, input bit rr, input logic [3:0] b);
    exp_t e;
    reset_n = ~rst; zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; botoes = b;
    if (rst) begin m_cnt = 0; m_reg = 0; m_prev = 0; end
    e.cont   = 4'(m_cnt);
    e.mem    = 4'(rom[m_cnt]);
    e.jog    = 4'(m_reg);
    e.fim    = (m_cnt == 15);
    e.igual  = (m_reg == rom[m_cnt]);
    e.tem    = (b != 4'h0);
    e.jogada = (b != 4'h0) && !m_prev;
    q.push_back(e);
    @(posedge clock); #1;
    if (!rst) begin
      if (zc)      m_cnt = 0;
      else if (cc) m_cnt = (m_cnt + 1) % 16;
      if (zr)      m_reg = 0;
      else if (rr) m_reg = int'(b);
      m_prev = (b != 4'h0);
    end
  endtask

  initial begin
    logic [3:0] b;
    @(posedge clock); #1;

    // Reset state, asserted mid-cycle
    step(1, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 4'h0);

    // Held button pulses once; release and press pulses again
    repeat (5) step(0, 0, 0, 0, 0, 4'b0010);
    step(0, 0, 0, 0, 0, 4'b0000);
    repeat (3) step(0, 0, 0, 0, 0, 4'b0010);
    // Second button joining a held one does not pulse
    step(0, 0, 0, 0, 0, 4'b0110);
    step(0, 0, 0, 0, 0, 4'b0000);

    // Count through all addresses and wrap, then clear beats count
    repeat (17) step(0, 0, 1, 0, 0, 4'h0);
    step(0, 1, 1, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 4'h0);

    // Counter to 3, load matching and non-matching plays
    repeat (3) step(0, 0, 1, 0, 0, 4'h0);
    step(0, 0, 0, 0, 1, 4'b1000);
    step(0, 0, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 1, 4'b0100);
    step(0, 0, 0, 0, 0, 4'b0000);

    // Clear beats load; multi-hot never matches
    step(0, 0, 0, 1, 1, 4'b1000);
    step(0, 1, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 1, 4'b0011);
    step(0, 0, 0, 0, 0, 4'b0000);

    // Count and load in the same cycle
    step(0, 0, 1, 0, 1, 4'b0010);
    step(0, 0, 0, 0, 0, 4'b0000);

    // Mid-round reset
    step(0, 0, 1, 0, 1, 4'b0100);
    step(1, 0, 0, 0, 0, 4'h0);
    step(1, 0, 1, 0, 1, 4'h0);
    step(0, 0, 0, 0, 0, 4'h0);

    // Full correct round
    for (int unsigned i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, 1, 4'(rom[i]));
      step(0, 0, 1, 0, 0, 4'h0);
    end

    // Randomized traffic
    b = 4'h0;
    for (int unsigned i = 0; i < 1500; i++) begin
      if ($urandom_range(1, 0) == 0) begin
        case ($urandom_range(9, 0))
          0, 1, 2, 3: b = 4'h0;
          4, 5, 6, 7: b = 4'(1 << $urandom_range(3, 0));
          default:    b = 4'($urandom);
        endcase
      end
      if ($urandom_range(99, 0) == 0)
        step(1, 0, 0, 0, 0, 4'h0);
      else
        step(0, $urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1,
             $urandom_range(7, 0) == 0, $urandom_range(2, 0) == 0, b);
    end

    @(negedge clock); #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
